clock_sequencer: RTL

- Parametrised CPU clock generator for the Ben8BitCPU; successor to the single-bit flip-flop clock component.
- Derives the CPU clock level Q/notQ from master clock C.
- Three behaviours: free-running divided clock (auto), debounced single-step pulse (manual), and a latched halt driven by the CPU HLT control line.
- Feeds every CPU register and the control sequencer; Tick gives same-domain logic a one-cycle enable.

---
 rtl/clock_sequencer_pkg.sv | 17 +
 rtl/clock_sequencer_debouncer.sv | 53 +++++
 rtl/clock_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/clock_sequencer_pkg.sv
// Shared constants for the CPU clock sequencer: FSM state encoding and Mode values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package clock_sequencer_pkg;

    // FSM state encoding, kept as plain 3-bit constants for compatibility with older tooling
    localparam logic [2:0] RUN_LOW   = 3'd0;
    localparam logic [2:0] RUN_HIGH  = 3'd1;
    localparam logic [2:0] STEP_WAIT = 3'd2;
    localparam logic [2:0] STEP_HIGH = 3'd3;
    localparam logic [2:0] HALTED    = 3'd4;

    // Mode input values
    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

endpackage

// File: rtl/clock_sequencer_debouncer.sv
// Synchronises and debounces the raw Step pushbutton; emits a one-cycle Press on each accepted 0->1.
// Latency: Level changes DEBOUNCE_CYCLES+2 cycles after a clean input edge; Press coincides with Level rising.
// Backpressure: none; Press is a pulse and is lost if the consumer is not listening that cycle.
//
// Ports:
//   C      master clock (posedge)
//   Reset  synchronous active-high reset; clears synchroniser, counter, Level and Press
//   In     raw asynchronous pushbutton input
//   Level  debounced level
//   Press  one-cycle pulse when Level goes 0->1
module clock_sequencer_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic C,
    input  logic Reset,
    input  logic In,
    output logic Level,
    output logic Press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the flip happens on the cycle that would hit DEBOUNCE_CYCLES.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge C) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            Level <= 1'b0;
            Press <= 1'b0;
        end else begin
            sync1 <= In;
            sync2 <= sync1;
            Press <= 1'b0;
            if (sync2 == Level) begin
                // Any cycle agreeing with the current level restarts the stability run.
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                Level <= sync2;
                Press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_sequencer.sv
// CPU clock generator: free-running divided clock, debounced single-step, or latched halt.
// Latency: each Q phase lasts Divisor+1 C cycles; a clean Step press raises Q on the (DEBOUNCE_CYCLES+3)th sampling edge.
// Backpressure: none; Halt and Mode are deferred until a high phase completes, presses during a high phase are dropped.
//
// Ports:
//   C        master clock (posedge)
//   Reset    synchronous active-high reset
//   Mode     0 = auto free-run, 1 = manual single-step
//   Step     raw bouncing pushbutton (asynchronous)
//   Halt     CPU HLT line, synchronous to C
//   Divisor  phase length minus one
//   Q/notQ   CPU clock level and its complement
//   Tick     one-cycle pulse in the first cycle Q reads 1
//   Halted   high while latched in the halt state
module clock_sequencer
    import clock_sequencer_pkg::*;
#(
    parameter int   DIVIDER_WIDTH   = 16,
    parameter int   DEBOUNCE_CYCLES = 8,
    parameter logic Default         = 1'b0
) (
    input  logic                     C,
    input  logic                     Reset,
    input  logic                     Mode,
    input  logic                     Step,
    input  logic                     Halt,
    input  logic [DIVIDER_WIDTH-1:0] Divisor,
    output logic                     Q,
    output logic                     notQ,
    output logic                     Tick,
    output logic                     Halted
);

    logic [2:0]               state;
    logic [2:0]               state_nxt;
    logic [DIVIDER_WIDTH-1:0] cnt;
    logic [DIVIDER_WIDTH-1:0] cnt_nxt;
    logic                     q_r;
    logic                     q_nxt;
    logic                     tick_r;
    logic                     tick_nxt;
    logic                     phase_end;
    logic                     step_level;
    logic                     step_press;

    clock_sequencer_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .C    (C),
        .Reset(Reset),
        .In   (Step),
        .Level(step_level),
        .Press(step_press)
    );

    // Compared against the live Divisor so lowering it mid-phase cuts the phase short on the next edge.
    assign phase_end = (cnt >= Divisor);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q_r;
        tick_nxt  = 1'b0;
        case (state)
            RUN_LOW: begin
                if (Halt) begin
                    state_nxt = HALTED;
                    cnt_nxt   = '0;
                end else if (Mode == MODE_MANUAL) begin
                    state_nxt = STEP_WAIT;
                    cnt_nxt   = '0;
                end else if (phase_end) begin
                    state_nxt = RUN_HIGH;
                    cnt_nxt   = '0;
                    q_nxt     = 1'b1;
                    tick_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN_HIGH, STEP_HIGH: begin
                // High phases always run to completion so the CPU never sees a runt pulse.
                if (phase_end) begin
                    cnt_nxt = '0;
                    q_nxt   = 1'b0;
                    if (Halt) begin
                        state_nxt = HALTED;
                    end else if (Mode == MODE_MANUAL) begin
                        state_nxt = STEP_WAIT;
                    end else begin
                        state_nxt = RUN_LOW;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STEP_WAIT: begin
                cnt_nxt = '0;
                if (Halt) begin
                    state_nxt = HALTED;
                end else if (Mode == MODE_AUTO) begin
                    state_nxt = RUN_LOW;
                end else if (step_press && step_level) begin
                    state_nxt = STEP_HIGH;
                    q_nxt     = 1'b1;
                    tick_nxt  = 1'b1;
                end
            end
            HALTED: begin
                // Sticky until Reset.
                cnt_nxt = '0;
                q_nxt   = 1'b0;
            end
            default: begin
                state_nxt = RUN_LOW;
                cnt_nxt   = '0;
                q_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (Reset) begin
            state  <= (Mode == MODE_MANUAL) ? STEP_WAIT : RUN_LOW;
            cnt    <= '0;
            q_r    <= Default;
            tick_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            q_r    <= q_nxt;
            tick_r <= tick_nxt;
        end
    end

    assign Q      = q_r;
    assign notQ   = ~q_r;
    assign Tick   = tick_r;
    assign Halted = (state == HALTED);

endmodule
